ahb_slave_interface: RTL

AHB-side front end of the AHB-to-APB bridge, sitting directly upstream of `APB_controller`. It does three things:
- Decodes the AHB address phase into `valid` and a one-hot peripheral select `tempselx`.
- Delays address, write data and direction by one and two cycles, producing the `Haddr1/Haddr2`, `Hwdata1/Hwdata2` and `Hwritereg` copies the controller consumes.
- Screens out misaligned or unsupported-size transfers with a standard two-cycle AHB ERROR response, so they never reach the APB side.

---
 rtl/ahb_slave_interface.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/ahb_slave_interface.sv
// AHB-side front end of the AHB-to-APB bridge.
// Decodes the address phase into valid/tempselx and delays the address, write
// data and direction for the APB controller. Misaligned or unsupported-size
// transfers get a two-cycle AHB ERROR response and never reach the APB side.
//
// Handshake: a transfer is accepted in its address phase when Hreadyin=1 and
// Htrans is NONSEQ/SEQ; valid marks that cycle combinationally. err_stall is
// a wait request that the top level folds into Hreadyout.
module ahb_slave_interface #(
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter logic [31:0] SLOT_SIZE = 32'h0400_0000
) (
    input  logic        Hclk,
    input  logic        Hresetin,
    input  logic        Hwrite,
    input  logic        Hreadyin,
    input  logic [1:0]  Htrans,
    input  logic [2:0]  Hsize,
    input  logic [31:0] Haddr,
    input  logic [31:0] Hwdata,
    input  logic [31:0] Prdata,
    output logic        valid,
    output logic [2:0]  tempselx,
    output logic [31:0] Haddr1,
    output logic [31:0] Haddr2,
    output logic [31:0] Hwdata1,
    output logic [31:0] Hwdata2,
    output logic        Hwritereg,
    output logic [31:0] Hrdata,
    output logic [1:0]  Hresp,
    output logic        err_stall,
    output logic [1:0]  o_dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ERR1 = 2'd1,
        ST_ERR2 = 2'd2
    } state_t;

    // Slot boundaries are kept in 34 bits so 3*SLOT_SIZE cannot wrap.
    localparam logic [33:0] SPAN1 = {2'b00, SLOT_SIZE};
    localparam logic [33:0] SPAN2 = {2'b00, SLOT_SIZE} * 34'd2;
    localparam logic [33:0] SPAN3 = {2'b00, SLOT_SIZE} * 34'd3;

    state_t      r_state;
    logic [33:0] w_offset;
    logic        w_in_win;
    logic        w_act;
    logic        w_mis;

    assign w_offset = {2'b00, Haddr - BASE_ADDR};
    assign w_in_win = (Haddr >= BASE_ADDR) && (w_offset < SPAN3);
    assign w_act    = Hreadyin & Htrans[1] & w_in_win;

    // One-hot slot select from the offset inside the bridge window.
    always_comb begin
        tempselx = 3'b000;
        if (w_in_win) begin
            if (w_offset < SPAN1) begin
                tempselx = 3'b001;
            end else if (w_offset < SPAN2) begin
                tempselx = 3'b010;
            end else begin
                tempselx = 3'b100;
            end
        end
    end

    // Alignment screen: sizes above a word are not supported by the APB side.
    always_comb begin
        w_mis = 1'b1;
        case (Hsize)
            3'b000:  w_mis = 1'b0;
            3'b001:  w_mis = Haddr[0];
            3'b010:  w_mis = |Haddr[1:0];
            default: w_mis = 1'b1;
        endcase
    end

    // New transfers are only accepted while no error response is in flight.
    assign valid       = w_act & ~w_mis & (r_state == ST_IDLE) & ~Hresetin;
    assign Hrdata      = Prdata;
    assign o_dbg_state = r_state;

    // Address/data/direction delay line consumed by the APB controller.
    always_ff @(posedge Hclk) begin
        if (Hresetin) begin
            Haddr1    <= 32'h0;
            Haddr2    <= 32'h0;
            Hwdata1   <= 32'h0;
            Hwdata2   <= 32'h0;
            Hwritereg <= 1'b0;
        end else begin
            Haddr1    <= Haddr;
            Haddr2    <= Haddr1;
            Hwdata1   <= Hwdata;
            Hwdata2   <= Hwdata1;
            Hwritereg <= Hwrite;
        end
    end

    // Two-cycle ERROR response: first cycle stalls the master, second releases it.
    always_ff @(posedge Hclk) begin
        if (Hresetin) begin
            r_state   <= ST_IDLE;
            Hresp     <= 2'b00;
            err_stall <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_act && w_mis) begin
                        r_state   <= ST_ERR1;
                        Hresp     <= 2'b01;
                        err_stall <= 1'b1;
                    end else begin
                        Hresp     <= 2'b00;
                        err_stall <= 1'b0;
                    end
                end
                ST_ERR1: begin
                    r_state   <= ST_ERR2;
                    Hresp     <= 2'b01;
                    err_stall <= 1'b0;
                end
                ST_ERR2: begin
                    // The master cancels whatever it presents here, so it is ignored.
                    r_state   <= ST_IDLE;
                    Hresp     <= 2'b00;
                    err_stall <= 1'b0;
                end
                default: begin
                    r_state   <= ST_IDLE;
                    Hresp     <= 2'b00;
                    err_stall <= 1'b0;
                end
            endcase
        end
    end

endmodule
